// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with
//            a show-ahead receive FIFO and framing/overrun pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int C_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int C_CW           = $clog2(C_CLKS_PER_BIT);
  localparam int C_AW           = $clog2(FIFO_DEPTH);
  localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(C_CLKS_PER_BIT - 1);
  localparam logic [C_CW-1:0] C_CNT_HALF = C_CW'(C_CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_WAITHI = 3'd5
  } state_t;

  logic            r_sync1;
  logic            r_rx_s;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [C_CW-1:0] r_cnt;
  logic [C_CW-1:0] w_cnt_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            w_bit_end;
  logic            w_push;
  logic            w_ferr;
  logic            w_par_bad;

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic w_par_err_nxt;
  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_bit_end = (r_cnt == C_CNT_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_err <= w_par_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_err_nxt = r_par_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == C_CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = r_rx_s;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          // Even parity: data plus parity bit must hold an even number of ones.
          w_par_err_nxt = ^{r_shift, r_rx_s};
          w_state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_ferr      = w_par_bad;
            w_push      = !w_par_bad;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        w_cnt_nxt = '0;
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rx_busy = (r_state != S_IDLE);

  // Receive FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [C_AW:0] r_wptr;
  logic [C_AW:0] r_rptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          r_frame_err;
  logic          r_overrun;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                   (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
  assign w_pop   = !w_empty && rx_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge sysclk) begin
    if (w_wr) r_mem[r_wptr[C_AW-1:0]] <= r_shift;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_frame_err <= w_ferr;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  assign rx_valid  = !w_empty;
  assign rx_data   = w_empty ? 8'h00 : r_mem[r_rptr[C_AW-1:0]];
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed, table-driven self-checking bench for uart_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 3125000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Edge index of the stop sample, counted from the edge before the start bit falls.
  localparam int STOP_EDGE = 3 + CPB / 2 + CPB * (9 + PB);

  logic       sysclk   = 1'b0;
  logic       reset    = 1'b1;
  logic       uart_rx  = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_busy = 0;
  int b_f, b_o, b_b;

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #10 sysclk = ~sysclk;

  // Pulse monitors count high cycles, so a stretched pulse shows up as >1.
  always @(negedge sysclk) begin
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
    if (rx_busy)   n_busy++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = ^d;
    tick(CPB);
`endif
    uart_rx = stop;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(d, stop);
    uart_rx = 1'b1;
    tick(4);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [31:0] exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h1B, 1'b1, 1'b1, 8'h1B, 32'd0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 32'd0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 32'd0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 32'd0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 32'd1};

    tick(3);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    tick(4);

    // Exact push latency on the first frame.
    b_f = n_ferr;
    fork
      send_frame(8'h1B, 1'b1);
      begin
        tick(STOP_EDGE - 1);
        chk("lat_pre_valid", 32'(rx_valid), 32'd0);
        tick(1);
        chk("lat_valid", 32'(rx_valid), 32'd1);
        chk("lat_data", 32'(rx_data), 32'h1B);
      end
    join
    chk("lat_ferr", 32'(n_ferr - b_f), 32'd0);
    pop_one();
    chk("lat_popped", 32'(rx_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      b_f = n_ferr;
      b_o = n_ovr;
      send_frame(vecs[i].data, vecs[i].stop);
      chk("vec_valid", 32'(rx_valid), 32'(vecs[i].exp_valid));
      chk("vec_data", 32'(rx_data), 32'(vecs[i].exp_data));
      chk("vec_ferr", 32'(n_ferr - b_f), vecs[i].exp_ferr);
      chk("vec_ovr", 32'(n_ovr - b_o), 32'd0);
      if (vecs[i].exp_valid) begin
        pop_one();
        chk("vec_empty", 32'(rx_valid), 32'd0);
      end
    end

    // Two frames back-to-back, then pop every cycle.
    send_frame(8'h1B, 1'b1);
    send_frame(8'h78, 1'b1);
    chk("b2b_head", 32'(rx_data), 32'h1B);
    rx_ready = 1'b1;
    tick(1);
    chk("b2b_second", 32'(rx_data), 32'h78);
    chk("b2b_valid", 32'(rx_valid), 32'd1);
    tick(1);
    chk("b2b_empty", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // Short low glitch: busy only for the half-bit START check.
    b_b = n_busy;
    b_f = n_ferr;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    chk("glitch_busy_cycles", 32'(n_busy - b_b), 32'(CPB / 2));
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_ferr", 32'(n_ferr - b_f), 32'd0);

    // Break: bad stop bit followed by the line held low.
    b_f = n_ferr;
    send_bits(8'h55, 1'b0);
    tick(3 * CPB);
    chk("break_waithi_busy", 32'(rx_busy), 32'd1);
    chk("break_ferr_once", 32'(n_ferr - b_f), 32'd1);
    uart_rx = 1'b1;
    tick(4);
    chk("break_idle", 32'(rx_busy), 32'd0);
    chk("break_valid", 32'(rx_valid), 32'd0);
    chk("break_ferr_total", 32'(n_ferr - b_f), 32'd1);

    // Overrun on the fifth byte with no consumer.
    b_o = n_ovr;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    chk("ovr_pulse", 32'(n_ovr - b_o), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_pop_data", 32'(rx_data), 32'(i));
      pop_one();
    end
    chk("ovr_empty", 32'(rx_valid), 32'd0);

    // Pop coinciding with the full-FIFO push keeps the fifth byte.
    b_o = n_ovr;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(STOP_EDGE - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    chk("nopush_ovr", 32'(n_ovr - b_o), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("nopush_pop_data", 32'(rx_data), 32'(i));
      pop_one();
    end
    chk("nopush_empty", 32'(rx_valid), 32'd0);

    // Reset in the middle of data bit 4 with a byte already buffered.
    send_frame(8'h3C, 1'b1);
    b_f = n_ferr;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick(88);
        chk("mid_busy_before", 32'(rx_busy), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(rx_busy), 32'd0);
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
      end
    join
    chk("mid_no_push", 32'(rx_valid), 32'd0);
    send_frame(8'h78, 1'b1);
    chk("post_rst_valid", 32'(rx_valid), 32'd1);
    chk("post_rst_data", 32'(rx_data), 32'h78);
    chk("post_rst_ferr", 32'(n_ferr - b_f), 32'd0);
    pop_one();
    chk("post_rst_empty", 32'(rx_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
